// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS-subset core with a shared req/ready memory port,
// an absorbing trap state for illegal encodings and a retired-instruction counter.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      pc,
    output logic [31:0]      ula_result,
    output logic             retire,
    output logic             trap,
    output logic [CNT_W-1:0] retired_count
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    state_t state;
    logic [31:0] ir, a, b, mdr, imm, alu;
    logic [31:0] rf [32];
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, wb_dst;
    logic is_r, is_jr, is_j, is_jal, is_lw, is_sw, is_beq, is_bne, is_addi, is_jump, legal, taken;

    assign op      = ir[31:26];
    assign funct   = ir[5:0];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign imm     = {{16{ir[15]}}, ir[15:0]};
    assign is_r    = op == 6'h00;
    assign is_jr   = is_r && funct == 6'h08;
    assign is_j    = op == 6'h02;
    assign is_jal  = op == 6'h03;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign is_beq  = op == 6'h04;
    assign is_bne  = op == 6'h05;
    assign is_addi = op == 6'h08;
    assign is_jump = is_j || is_jal || is_jr;
    assign legal   = is_r ? funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08}
                          : (is_lw || is_sw || is_beq || is_bne || is_addi || is_j || is_jal);
    assign taken   = is_beq ? a == b : a != b;
    assign wb_dst  = is_r ? rd : rt;

    always_comb
        alu = !is_r            ? a + imm :
              funct == 6'h22   ? a - b :
              funct == 6'h24   ? a & b :
              funct == 6'h25   ? a | b :
              funct == 6'h2A   ? {31'b0, $signed(a) < $signed(b)} :
              funct == 6'h00   ? b << ir[10:6] :
              funct == 6'h02   ? b >> ir[10:6] : a + b;

    // Request signals derive from state and registers that stay frozen while waiting.
    assign mem_we    = state == MEM && is_sw;
    assign mem_wdata = b;
    assign mem_addr  = state == MEM ? {ula_result[31:2], 2'b00} : {pc[31:2], 2'b00};
    assign trap      = state == TRAP;
    assign retire    = (state == DECODE && legal && is_jump) || (state == EXEC && (is_beq || is_bne)) ||
                       (state == MEM && is_sw && mem_req && mem_ready) || state == WB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            mem_req       <= 1'b0;
            ir            <= '0;
            a             <= '0;
            b             <= '0;
            mdr           <= '0;
            ula_result    <= '0;
            retired_count <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (retire) retired_count <= retired_count + 1'b1;
            case (state)
                FETCH: begin
                    if (!mem_req) mem_req <= 1'b1;
                    else if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + 32'd4;
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a          <= rf[rs];
                    b          <= rf[rt];
                    ula_result <= pc + (imm << 2);
                    if (!legal) state <= TRAP;
                    else if (is_jump) begin
                        pc      <= is_jr ? rf[rs] : {pc[31:28], ir[25:0], 2'b00};
                        if (is_jal) rf[31] <= pc;
                        mem_req <= 1'b1;
                        state   <= FETCH;
                    end else state <= EXEC;
                end
                EXEC: begin
                    if (is_beq || is_bne) begin
                        if (taken) pc <= ula_result;
                        mem_req <= 1'b1;
                        state   <= FETCH;
                    end else begin
                        ula_result <= alu;
                        mem_req    <= is_lw || is_sw;
                        state      <= (is_lw || is_sw) ? MEM : WB;
                    end
                end
                MEM: begin
                    if (mem_req && mem_ready) begin
                        mdr     <= mem_rdata;
                        mem_req <= is_sw;
                        state   <= is_sw ? FETCH : WB;
                    end
                end
                WB: begin
                    if (wb_dst != 5'd0) rf[wb_dst] <= is_lw ? mdr : ula_result;
                    mem_req <= 1'b1;
                    state   <= FETCH;
                end
                TRAP: state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: ISA-level reference model plus a wait-state memory responder;
// directed programs pin the model, random programs exercise the core against it.
module tb_mips_multicycle;
    localparam int CW = 4;
    logic clock = 1'b0, reset = 1'b1, mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic mem_req, mem_we, retire, trap;
    logic [31:0] mem_addr, mem_wdata, pc, ula_result;
    logic [CW-1:0] retired_count;

    mips_multicycle #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .ula_result(ula_result), .retire(retire), .trap(trap), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_err = 0;
    logic [31:0] prog [512];
    logic [31:0] mem [512];
    logic [31:0] r [32];
    logic [31:0] mpc, p_addr, p_wdata, wea, wed;
    logic [CW-1:0] mcnt;
    logic p_we;
    int n_ret, cyc, waits, gcyc, trap_cycle, wec, nwrites, wmode, wl, wr_reg;
    bit idle, pend, prev_stall, trap_seen, req_prev, rdy_prev;
    int ret_cyc[$];
    logic [31:0] pc_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_ins(input logic [31:0] w);
        logic [5:0] op, f;
        op = w[31:26];
        f  = w[5:0];
        if (op == 6'h00) return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
        return op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03};
    endfunction

    // Executes one whole instruction at the architectural level; base=0 marks an illegal one.
    task automatic model_step(output int base, output int dst, output bit st,
                              output logic [31:0] sa, output logic [31:0] sd);
        logic [31:0] w, a, b, se, npc, res, ad;
        w = mem[mpc[10:2]];
        a = r[w[25:21]];
        b = r[w[20:16]];
        se = {{16{w[15]}}, w[15:0]};
        npc = mpc + 32'd4;
        ad = a + se;
        dst = 0; st = 0; sa = '0; sd = '0; res = '0; base = 4;
        case (w[31:26])
            6'h00: begin
                dst = int'(w[15:11]);
                case (w[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: res = b << w[10:6];
                    6'h02: res = b >> w[10:6];
                    6'h08: begin npc = a; dst = 0; base = 2; end
                    default: begin base = 0; dst = 0; end
                endcase
            end
            6'h08: begin dst = int'(w[20:16]); res = ad; end
            6'h23: begin dst = int'(w[20:16]); res = mem[ad[10:2]]; base = 5; end
            6'h2B: begin st = 1; sa = {ad[31:2], 2'b00}; sd = b; end
            6'h04: begin base = 3; if (a == b) npc = mpc + 32'd4 + (se << 2); end
            6'h05: begin base = 3; if (a != b) npc = mpc + 32'd4 + (se << 2); end
            6'h02: begin base = 2; npc = {npc[31:28], w[25:0], 2'b00}; end
            6'h03: begin base = 2; dst = 31; res = mpc + 32'd4; npc = {npc[31:28], w[25:0], 2'b00}; end
            default: base = 0;
        endcase
        if (dst != 0) r[dst] = res;
        if (st) mem[sa[10:2]] = sd;
        mpc = npc;
    endtask

    // Memory responder: decides ready/rdata just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            mem_ready = 1'b0;
            req_prev  = 1'b0;
            rdy_prev  = 1'b0;
        end else begin
            if (mem_req) begin
                if (!req_prev || rdy_prev)
                    wl = wmode == 1 ? 2 : wmode == 2 ? int'($urandom_range(0, 2)) :
                         wmode == 3 ? (mem_we ? 1000 : 0) : 0;
                mem_ready = wl == 0;
                if (wl > 0) wl--;
                mem_rdata = mem[mem_addr[10:2]];
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            req_prev = mem_req;
            rdy_prev = mem_ready;
        end
    end

    // Compare process: one pass per cycle on the falling edge.
    always @(negedge clock) begin
        int base, dst;
        bit st;
        logic [31:0] sa, sd;
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] = prog[i];
            for (int i = 0; i < 32; i++) r[i] = '0;
            mpc = '0; mcnt = '0; n_ret = 0; cyc = 0; waits = 0; gcyc = 0; trap_cycle = 0;
            wec = 0; nwrites = 0; idle = 1; pend = 0; prev_stall = 0; trap_seen = 0;
            ret_cyc.delete();
            pc_log.delete();
        end else if (idle) begin
            chk("idle_req", 32'(mem_req), 32'd0);
            chk("idle_pc", pc, 32'h0);
            chk("idle_count", 32'(retired_count), 32'd0);
            idle = 0;
        end else begin
            gcyc++;
            cyc++;
            if (prev_stall) begin
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_we", 32'(mem_we), 32'(p_we));
                chk("hold_wdata", mem_wdata, p_wdata);
            end
            if (mem_req) chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
            if (mem_req && !mem_ready) waits++;
            prev_stall = mem_req && !mem_ready;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            if (mem_req && mem_we) begin wec++; wea = mem_addr; wed = mem_wdata; end
            if (mem_req && mem_ready && mem_we) nwrites++;
            if (trap) begin
                if (!trap_seen) begin
                    trap_cycle = gcyc;
                    chk("trap_pc", pc, mpc + 32'd4);
                    chk("trap_illegal", 32'(legal_ins(mem[mpc[10:2]])), 32'd0);
                end
                trap_seen = 1;
                chk("trap_req", 32'(mem_req), 32'd0);
                chk("trap_retire", 32'(retire), 32'd0);
                chk("trap_count", 32'(retired_count), 32'(mcnt));
            end
            if (pend) begin
                chk("pc", pc, mpc);
                chk("count", 32'(retired_count), 32'(mcnt));
                chk("r0", dut.rf[0], 32'h0);
                if (wr_reg != 0) chk("reg", dut.rf[wr_reg], r[wr_reg]);
                pc_log.push_back(pc);
                pend = 0;
            end
            if (retire) begin
                model_step(base, dst, st, sa, sd);
                chk("latency", 32'(cyc), 32'(base + waits));
                if (st) begin
                    chk("st_we", 32'(mem_we), 32'd1);
                    chk("st_addr", mem_addr, sa);
                    chk("st_data", mem_wdata, sd);
                end
                wr_reg = dst;
                cyc = 0; waits = 0; n_ret++; mcnt++;
                ret_cyc.push_back(gcyc);
                pend = 1;
            end
        end
    end

    function automatic logic [31:0] rt_(input logic [5:0] f, input int s, t, d, sh);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), f};
    endfunction
    function automatic logic [31:0] it_(input logic [5:0] op, input int s, t, input logic [15:0] imm);
        return {op, 5'(s), 5'(t), imm};
    endfunction
    function automatic logic [31:0] jt_(input logic [5:0] op, input int tg);
        return {op, 26'(tg)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 512; i++) prog[i] = 32'hFC00_0000;
    endtask

    task automatic start(input int mode);
        wmode = mode;
        @(posedge clock); #3 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic run(input int nret, input int budget, input string name);
        int k = 0;
        while (!trap_seen && n_ret < nret && k < budget) begin
            @(posedge clock);
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
        #2;
    endtask

    initial begin
        logic [5:0] fs [7];
        fs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        clear_prog();
        // addi/addi/add with zero wait states
        prog[0] = it_(6'h08, 0, 1, 16'd5);
        prog[1] = it_(6'h08, 0, 2, 16'hFFFD);
        prog[2] = rt_(6'h20, 1, 2, 3, 0);
        start(0);
        run(1000, 200, "t1_done");
        chk("t1_nret", 32'(ret_cyc.size()), 32'd3);
        chk("t1_ret0", 32'(ret_cyc[0]), 32'd4);
        chk("t1_ret1", 32'(ret_cyc[1]), 32'd8);
        chk("t1_ret2", 32'(ret_cyc[2]), 32'd12);
        chk("t1_r3", dut.rf[3], 32'd2);
        chk("t1_trapcyc", 32'(trap_cycle), 32'd15);
        repeat (10) @(posedge clock);
        #2;
        chk("t1_frozen", 32'(retired_count), 32'd3);
        chk("t1_trap", 32'(trap), 32'd1);
        chk("t1_trap_pc", pc, 32'h10);
        @(posedge clock); #3 reset = 1'b1;
        #1;
        chk("t1_rst_trap", 32'(trap), 32'd0);
        chk("t1_rst_pc", pc, 32'h0);
        chk("t1_rst_req", 32'(mem_req), 32'd0);

        // sw then lw with two wait states per access
        prog[3] = it_(6'h2B, 0, 3, 16'd8);
        prog[4] = it_(6'h23, 0, 4, 16'd8);
        start(1);
        run(1000, 400, "t2_done");
        chk("t2_r4", dut.rf[4], 32'd2);
        chk("t2_sw_cyc", 32'(ret_cyc[3] - ret_cyc[2]), 32'd8);
        chk("t2_lw_cyc", 32'(ret_cyc[4] - ret_cyc[3]), 32'd9);
        chk("t2_we_cycles", 32'(wec), 32'd3);
        chk("t2_we_addr", wea, 32'd8);
        chk("t2_we_data", wed, 32'd2);
        chk("t2_writes", 32'(nwrites), 32'd1);

        // beq back-edge loop; 17 retirements wrap the 4-bit counter to 1
        clear_prog();
        prog[0] = it_(6'h08, 0, 1, 16'd1);
        for (int i = 1; i < 4; i++) prog[i] = 32'h0;
        prog[4] = it_(6'h04, 1, 1, 16'hFFFF);
        start(0);
        run(17, 200, "t3_done");
        chk("t3_pc", pc, 32'h10);
        chk("t3_count", 32'(retired_count), 32'd1);
        chk("t3_beq_cyc", 32'(ret_cyc[16] - ret_cyc[15]), 32'd3);

        // bne not taken falls through to an illegal opcode
        prog[4] = it_(6'h05, 1, 1, 16'd5);
        start(0);
        run(1000, 200, "t4_done");
        chk("t4_pc_after_bne", pc_log[4], 32'h14);
        chk("t4_trap_delay", 32'(trap_cycle - ret_cyc[4]), 32'd3);
        chk("t4_count", 32'(retired_count), 32'd5);

        // jal to 0x100 then jr back
        clear_prog();
        for (int i = 0; i < 8; i++) prog[i] = 32'h0;
        prog[8] = jt_(6'h03, 32'h40);
        prog[64] = rt_(6'h08, 31, 0, 0, 0);
        start(0);
        run(1000, 300, "t5_done");
        chk("t5_r31", dut.rf[31], 32'h24);
        chk("t5_pc_jal", pc_log[8], 32'h100);
        chk("t5_pc_jr", pc_log[9], 32'h24);
        chk("t5_jal_cyc", 32'(ret_cyc[8] - ret_cyc[7]), 32'd2);
        chk("t5_jr_cyc", 32'(ret_cyc[9] - ret_cyc[8]), 32'd2);

        // undefined R-type funct traps immediately
        clear_prog();
        prog[0] = rt_(6'h3F, 1, 2, 3, 0);
        start(0);
        run(1000, 100, "t6_done");
        chk("t6_nret", 32'(n_ret), 32'd0);
        chk("t6_trapcyc", 32'(trap_cycle), 32'd3);

        // async reset during a stalled store: no write, restart from RESET_PC
        clear_prog();
        prog[0] = it_(6'h08, 0, 5, 16'd7);
        prog[1] = it_(6'h2B, 0, 5, 16'h0400);
        start(3);
        begin
            int k = 0;
            while (wec < 4 && k < 200) begin @(posedge clock); k++; end
            chk("t7_stall", 32'(k < 200), 32'd1);
        end
        #3 reset = 1'b1;
        #1;
        chk("t7_req", 32'(mem_req), 32'd0);
        chk("t7_we", 32'(mem_we), 32'd0);
        chk("t7_nowrite", 32'(nwrites), 32'd0);
        repeat (2) @(posedge clock);
        wmode = 0;
        #2 reset = 1'b0;
        run(1000, 200, "t7_done");
        chk("t7_r5", dut.rf[5], 32'd7);
        chk("t7_writes", 32'(nwrites), 32'd1);
        chk("t7_count", 32'(retired_count), 32'd2);

        // random forward-only programs with random wait states
        for (int s = 0; s < 3; s++) begin
            clear_prog();
            for (int i = 256; i < 320; i++) prog[i] = $urandom;
            for (int i = 0; i < 7; i++) prog[i] = it_(6'h08, 0, i + 1, 16'($urandom));
            for (int i = 7; i < 60; i++) begin
                int kind, off, f;
                kind = int'($urandom_range(0, 9));
                off = int'($urandom_range(0, 3));
                if (i + 1 + off > 60) off = 59 - i;
                f = int'($urandom_range(0, 6));
                case (kind)
                    0, 1, 2: prog[i] = rt_(fs[f], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                           int'($urandom_range(0, 7)),
                                           (fs[f] == 6'h00 || fs[f] == 6'h02) ? int'($urandom_range(0, 31)) : 0);
                    3: prog[i] = it_(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
                    4: prog[i] = it_(6'h23, 0, int'($urandom_range(1, 7)), 16'h0400 + 16'($urandom_range(0, 255)));
                    5: prog[i] = it_(6'h2B, 0, int'($urandom_range(0, 7)), 16'h0400 + 16'($urandom_range(0, 255)));
                    6: prog[i] = it_(6'h04, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 16'(off));
                    7: prog[i] = it_(6'h05, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 16'(off));
                    8: prog[i] = jt_(6'h02, i + 1 + off);
                    default: prog[i] = jt_(6'h03, i + 1 + off);
                endcase
            end
            start(2);
            run(1000000, 6000, "rand_done");
            chk("rand_trap", 32'(trap), 32'd1);
            for (int i = 0; i < 32; i++) chk("rand_reg", dut.rf[i], r[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
Multi-cycle MIPS-subset core, successor to the single-cycle datapath. One shared instruction/data memory port with a req/ready handshake, so memory may insert any number of wait states. A 5-state-class FSM sequences fetch/decode/execute/memory/writeback and reuses one ALU. Adds a trap state for illegal opcodes, a per-instruction retire pulse and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 32, width of retired_count; the counter wraps modulo 2^CNT_W.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
mem_req  output  1  memory request valid.
mem_we  output  1  1 = write (sw), 0 = read; valid only while mem_req=1.
mem_addr  output  32  byte address, word aligned.
mem_wdata  output  32  store data.
mem_rdata  input  32  read data, sampled on the cycle mem_ready=1.
mem_ready  input  1  completes the current request.
pc  output  32  architectural PC.
ula_result  output  32  ALU output register (ALUOut).
retire  output  1  one-cycle pulse when an instruction completes.
trap  output  1  high while in TRAP.
retired_count  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (async, any state, including mid-request): pc=RESET_PC, state=FETCH, mem_req=0, IR/A/B/ALUOut/MDR=0, all 32 registers=0, retire=0, trap=0, retired_count=0. The first request issues on the first clock edge after reset deasserts.
- Register file: 32x32. Reads of $0 return 0. Writes to $0 are ignored.
- Supported instructions:
  - R-type (funct): add 20h, sub 22h, and 24h, or 25h, slt 2Ah, sll 00h (shamt), srl 02h, jr 08h.
  - I/J-type (opcode): lw 23h, sw 2Bh, beq 04h, bne 05h, addi 08h, j 02h, jal 03h.
  - Any other opcode, or an R-type funct not listed, goes to TRAP.
- Arithmetic: 32-bit wrap, no overflow exceptions. slt is signed. addi/lw/sw use a sign-extended imm16. Branch target = pc+4 + (sext(imm16)<<2). Jump target = {pc_plus4[31:28], imm26, 2'b00}.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ready=1 is sampled.
  - mem_req drops in the following cycle.
  - mem_ready while mem_req=0 is ignored.
  - There is no timeout; the core waits indefinitely.
- FSM:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=branch target. Illegal encoding goes to TRAP. j/jal/jr complete here: pc<=target, jal writes $31<=pc (already pc+4), retire, then FETCH. All other instructions go to EXEC.
  - EXEC:
    - R/addi: ALUOut<=result, then WB.
    - lw/sw: ALUOut<=A+sext, then MEM.
    - beq/bne: compare A,B; if taken pc<=ALUOut; retire; then FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut; sw drives mem_we=1, mem_wdata=B. On mem_ready: lw latches MDR and goes to WB; sw retires and goes to FETCH.
  - WB: rf[rd or rt]<=ALUOut (or MDR for lw); retire; then FETCH.
  - TRAP: absorbing, trap=1, mem_req=0, no register or PC writes; exits only on reset.
- Cycle counts with zero wait states (mem_ready=1 in the first request cycle): j/jal/jr 2, beq/bne 3, R/addi 4, sw 4, lw 5. Each wait cycle adds 1 to the memory state it occurs in.
- retire is asserted in the last cycle of an instruction. retired_count increments by 1 in the same cycle, wrapping to 0 after all ones.
- mem_addr[1:0] is always 00. Misaligned lw/sw addresses are truncated (low bits forced to 0), not trapped.

Test Plan:
- Reset, mem_ready tied 1, program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2" -> $3=2; retire pulses at cycles 4, 8, 12; retired_count=3.
- "sw $3,8($0)" then "lw $4,8($0)" with 2 wait cycles per access -> the write request holds addr=8, wdata=2 stable for 3 cycles; $4=2; the lw takes 5+2+2=9 cycles.
- "beq $1,$1,-1" at pc=0x10 -> pc returns to 0x10 after 3 cycles. "bne $1,$1,X" -> pc=0x14.
- "jal 0x40" at pc=0x20 -> $31=0x24 and pc=0x100 in 2 cycles. "jr $31" -> pc=0x24.
- Opcode 3Fh fetched -> trap=1 next cycle, mem_req stays 0, retired_count frozen. Asserting reset -> trap=0, pc=RESET_PC.
- Reset asserted mid-MEM wait state of a sw -> mem_req=0 immediately (asynchronous), no write occurs, FETCH restarts at RESET_PC. With CNT_W=4, 17 retirements -> retired_count=1.
